// File: rtl/control_pipe.sv
// Registered instruction decoder with RAW scoreboard, multiply wait and timeout.
module control_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SB_DEPTH    = 3,
  parameter int unsigned MUL_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  output logic                  instr_ready,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [24:0]           ctrl,
  output logic [DATA_WIDTH-1:0] jmp_address,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  illegal,
  input  logic                  mul_done,
  input  logic                  flush,
  output logic                  mul_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(MUL_TIMEOUT);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_LW    = 6'd40;
  localparam logic [5:0] OP_SW    = 6'd41;
  localparam logic [5:0] OP_BNE   = 6'd42;
  localparam logic [5:0] OP_ADDI  = 6'd43;
  localparam logic [5:0] OP_ORI   = 6'd44;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_MUL   = 6'd50;

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic mul_err_next;

  logic [SB_DEPTH-1:0]      sb_valid;
  logic [SB_DEPTH-1:0][4:0] sb_rd;

  logic [5:0] opcode, funct;
  logic [4:0] f_rs, f_rt, d_rd;
  logic d_wr, d_mi, d_mul, d_m2, d_wm, d_cs, d_br, d_j, d_ill;
  logic [1:0] d_alu;
  logic [DATA_WIDTH-1:0] d_imm, d_jmp, sext, zext;
  logic rs_used, rt_used, hazard, accept, handoff;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign f_rs   = instr[25:21];
  assign f_rt   = instr[20:16];
  assign sext   = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
  assign zext   = DATA_WIDTH'(instr[15:0]);

  // Decode the offered word into control fields and source-usage flags
  always_comb begin
    d_rd = 5'd0; d_wr = 1'b0; d_mi = 1'b0; d_alu = 2'b00; d_mul = 1'b0;
    d_m2 = 1'b0; d_wm = 1'b0; d_cs = 1'b0; d_br = 1'b0; d_j = 1'b0;
    d_ill = 1'b0; d_imm = '0; d_jmp = '0;
    rs_used = 1'b1; rt_used = 1'b0;
    case (opcode)
      OP_LW:   begin d_wr = 1'b1; d_mi = 1'b1; d_m2 = 1'b1; d_rd = f_rt; d_imm = sext; end
      OP_SW:   begin d_wm = 1'b1; d_mi = 1'b1; d_m2 = 1'b1; d_rd = f_rs; d_imm = sext;
                     rt_used = 1'b1; end
      OP_BNE:  begin d_alu = 2'b01; d_br = 1'b1; d_mi = 1'b1; d_m2 = 1'b1; d_imm = sext;
                     rt_used = 1'b1; end
      OP_ADDI: begin d_wr = 1'b1; d_mi = 1'b1; d_m2 = 1'b1; d_cs = 1'b1; d_rd = f_rt;
                     d_imm = sext; end
      OP_ORI:  begin d_alu = 2'b11; d_wr = 1'b1; d_mi = 1'b1; d_m2 = 1'b1; d_cs = 1'b1;
                     d_rd = f_rt; d_imm = zext; end
      OP_J:    begin d_j = 1'b1; d_mi = 1'b1; d_m2 = 1'b1; d_cs = 1'b1;
                     d_jmp = DATA_WIDTH'(instr[25:0]); rs_used = 1'b0; end
      OP_RTYPE: begin
        d_rd = instr[15:11]; d_wr = 1'b1; d_cs = 1'b1; rt_used = 1'b1;
        case (funct)
          FN_ADD:  begin d_alu = 2'b00; d_m2 = 1'b1; end
          FN_SUB:  begin d_alu = 2'b01; d_m2 = 1'b1; end
          FN_AND:  begin d_alu = 2'b10; d_m2 = 1'b1; end
          FN_OR:   begin d_alu = 2'b11; d_m2 = 1'b1; end
          FN_MUL:  begin d_mul = 1'b1; end
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_wr = 1'b0; d_wm = 1'b0; d_mul = 1'b0; d_br = 1'b0; d_j = 1'b0;
    end
  end

  // Read-after-write check against the scoreboard and the output register
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      if (sb_valid[i] && rs_used && f_rs != 5'd0 && sb_rd[i] == f_rs) hazard = 1'b1;
      if (sb_valid[i] && rt_used && f_rt != 5'd0 && sb_rd[i] == f_rt) hazard = 1'b1;
    end
    if (dec_valid && ctrl[9]) begin
      if (rs_used && f_rs != 5'd0 && ctrl[14:10] == f_rs) hazard = 1'b1;
      if (rt_used && f_rt != 5'd0 && ctrl[14:10] == f_rt) hazard = 1'b1;
    end
  end

  assign instr_ready = (state == RUN) && !hazard && !flush && (!dec_valid || dec_ready);
  assign accept      = instr_valid && instr_ready;
  assign handoff     = dec_valid && dec_ready;
  assign busy        = (state != RUN);

  // Output register: load on accept, clear on flush or drained handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid   <= 1'b0;
      ctrl        <= '0;
      jmp_address <= '0;
      imm         <= '0;
      illegal     <= 1'b0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (accept) begin
      dec_valid   <= 1'b1;
      ctrl        <= {f_rs, f_rt, d_rd, d_wr, d_mi, d_alu, d_mul, d_m2, d_wm, d_cs, d_br, d_j};
      jmp_address <= d_jmp;
      imm         <= d_imm;
      illegal     <= d_ill;
    end else if (handoff) begin
      dec_valid <= 1'b0;
    end
  end

  // Scoreboard shift register of in-flight writeback destinations
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid <= '0;
      sb_rd    <= '0;
    end else begin
      for (int i = int'(SB_DEPTH) - 1; i > 0; i--) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end
      sb_valid[0] <= handoff && ctrl[9];
      sb_rd[0]    <= handoff ? ctrl[14:10] : 5'd0;
    end
  end

  // FSM state, timeout counter and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      mul_err <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      mul_err <= mul_err_next;
    end
  end

  // FSM next-state: wait for mul_done after a MUL leaves, bounded by the timeout
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    mul_err_next = mul_err;
    case (state)
      RUN: begin
        if (handoff && ctrl[5]) begin
          state_next = MUL_WAIT;
          cnt_next   = '0;
        end
      end
      MUL_WAIT: begin
        if (mul_done) begin
          state_next = RUN;
        end else if (cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
          state_next   = RUN;
          mul_err_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe with hand-computed expectations.
module tb_control_pipe;

  logic        clk = 1'b0;
  logic        rst, instr_valid, dec_ready, mul_done, flush;
  logic [31:0] instr;
  logic        instr_ready, dec_valid, illegal, mul_err, busy;
  logic [24:0] ctrl;
  logic [31:0] jmp_address, imm;

  int n_vec = 0;
  int n_err = 0;

  control_pipe #(.DATA_WIDTH(32), .SB_DEPTH(3), .MUL_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .ctrl(ctrl), .jmp_address(jmp_address), .imm(imm), .illegal(illegal),
    .mul_done(mul_done), .flush(flush), .mul_err(mul_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] pk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic wr, input logic mi,
                                     input logic [1:0] alu, input logic mul, input logic m2,
                                     input logic wm, input logic cs, input logic br,
                                     input logic j);
    return {rs, rt, rd, wr, mi, alu, mul, m2, wm, cs, br, j};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer one word that must be accepted immediately; returns one cycle later
  task automatic issue(input string tag, input logic [31:0] w);
    instr = w;
    instr_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(instr_ready), 64'd1);
    step();
    instr_valid = 1'b0;
  endtask

  int stalls;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; dec_ready = 1'b1;
    mul_done = 1'b0; flush = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 64'(dec_valid), 64'd0);
    chk("rst_ctrl", 64'(ctrl), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_jmp", 64'(jmp_address), 64'd0);
    chk("rst_ill", 64'(illegal), 64'd0);
    chk("rst_err", 64'(mul_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // ADDI $3,$1,-4 then dependent ADD $4,$3,$2 stalls until $3 ages out
    issue("addi", 32'hAC23FFFC);
    chk("addi_valid", 64'(dec_valid), 64'd1);
    chk("addi_ctrl", 64'(ctrl), 64'(pk(5'd1, 5'd3, 5'd3, 1, 1, 2'b00, 0, 1, 0, 1, 0, 0)));
    chk("addi_imm", 64'(imm), 64'hFFFFFFFC);
    chk("addi_ill", 64'(illegal), 64'd0);
    instr = rtype(5'd3, 5'd2, 5'd4, 6'd32);
    instr_valid = 1'b1;
    stalls = 0;
    #1;
    while (!instr_ready && stalls < 20) begin
      step();
      stalls++;
    end
    chk("raw_stalls", 64'(stalls), 64'd4);
    step();
    instr_valid = 1'b0;
    chk("add_valid", 64'(dec_valid), 64'd1);
    chk("add_ctrl", 64'(ctrl), 64'(pk(5'd3, 5'd2, 5'd4, 1, 0, 2'b00, 0, 1, 0, 1, 0, 0)));
    idle(5);

    // ORI zero-extends its immediate
    issue("ori", itype(6'd44, 5'd0, 5'd5, 16'h8000));
    chk("ori_ctrl", 64'(ctrl), 64'(pk(5'd0, 5'd5, 5'd5, 1, 1, 2'b11, 0, 1, 0, 1, 0, 0)));
    chk("ori_imm", 64'(imm), 64'h00008000);
    idle(5);

    // A write to $0 never creates a hazard
    issue("addi0", itype(6'd43, 5'd1, 5'd0, 16'd5));
    instr = rtype(5'd0, 5'd0, 5'd8, 6'd32);
    instr_valid = 1'b1;
    #1;
    chk("zero_nostall", 64'(instr_ready), 64'd1);
    step();
    instr_valid = 1'b0;
    chk("zero_add_ctrl", 64'(ctrl), 64'(pk(5'd0, 5'd0, 5'd8, 1, 0, 2'b00, 0, 1, 0, 1, 0, 0)));
    idle(5);

    // LW, SW, BNE field decode
    issue("lw", itype(6'd40, 5'd1, 5'd11, 16'd8));
    chk("lw_ctrl", 64'(ctrl), 64'(pk(5'd1, 5'd11, 5'd11, 1, 1, 2'b00, 0, 1, 0, 0, 0, 0)));
    chk("lw_imm", 64'(imm), 64'd8);
    idle(5);
    issue("sw", itype(6'd41, 5'd2, 5'd12, 16'hFFF0));
    chk("sw_ctrl", 64'(ctrl), 64'(pk(5'd2, 5'd12, 5'd2, 0, 1, 2'b00, 0, 1, 1, 0, 0, 0)));
    chk("sw_imm", 64'(imm), 64'hFFFFFFF0);
    idle(5);
    issue("bne", itype(6'd42, 5'd3, 5'd4, 16'h0010));
    chk("bne_ctrl", 64'(ctrl), 64'(pk(5'd3, 5'd4, 5'd0, 0, 1, 2'b01, 0, 1, 0, 0, 1, 0)));
    chk("bne_imm", 64'(imm), 64'h10);
    idle(5);

    // MUL with mul_done five cycles after handoff, ADD waits then enters
    issue("mul", rtype(5'd1, 5'd2, 5'd9, 6'd50));
    chk("mul_ctrl", 64'(ctrl), 64'(pk(5'd1, 5'd2, 5'd9, 1, 0, 2'b00, 1, 0, 0, 1, 0, 0)));
    chk("mul_hand_busy", 64'(busy), 64'd0);
    step();
    instr = rtype(5'd1, 5'd2, 5'd10, 6'd32);
    instr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mul_done = (k == 4);
      #1;
      chk("mw_busy", 64'(busy), 64'd1);
      chk("mw_rdy", 64'(instr_ready), 64'd0);
      step();
    end
    mul_done = 1'b0;
    chk("mw_done_busy", 64'(busy), 64'd0);
    chk("mw_done_rdy", 64'(instr_ready), 64'd1);
    step();
    instr_valid = 1'b0;
    chk("mw_add_valid", 64'(dec_valid), 64'd1);
    chk("mw_add_rd", 64'(ctrl[14:10]), 64'd10);
    chk("mw_err", 64'(mul_err), 64'd0);
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    chk("run_done_ign", 64'(busy), 64'd0);
    idle(5);

    // MUL without mul_done times out after 64 cycles in MUL_WAIT
    issue("mul_to", rtype(5'd1, 5'd2, 5'd9, 6'd50));
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k == 0 || k == 63) begin
        chk("to_busy", 64'(busy), 64'd1);
        chk("to_err_early", 64'(mul_err), 64'd0);
      end
      step();
    end
    chk("to_run", 64'(busy), 64'd0);
    chk("to_err", 64'(mul_err), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("to_err_clr", 64'(mul_err), 64'd0);
    idle(2);

    // J held under backpressure, then flushed
    dec_ready = 1'b0;
    issue("j", {6'd2, 26'h0123456});
    chk("j_valid", 64'(dec_valid), 64'd1);
    chk("j_bits", 64'(ctrl[9:0]), 64'b0100010101);
    chk("j_rd", 64'(ctrl[14:10]), 64'd0);
    chk("j_addr", 64'(jmp_address), 64'h00123456);
    instr = itype(6'd43, 5'd1, 5'd3, 16'd1);
    instr_valid = 1'b1;
    #1;
    chk("hold_rdy", 64'(instr_ready), 64'd0);
    step();
    chk("hold_valid", 64'(dec_valid), 64'd1);
    chk("hold_addr", 64'(jmp_address), 64'h00123456);
    flush = 1'b1;
    #1;
    chk("flush_rdy", 64'(instr_ready), 64'd0);
    step();
    flush = 1'b0;
    instr_valid = 1'b0;
    chk("flush_valid", 64'(dec_valid), 64'd0);
    dec_ready = 1'b1;
    idle(4);

    // Unsupported opcode and funct are flagged and stripped of side effects
    issue("op7", {6'd7, 26'h3FFFFFF});
    chk("op7_valid", 64'(dec_valid), 64'd1);
    chk("op7_ill", 64'(illegal), 64'd1);
    chk("op7_bits", 64'({ctrl[9], ctrl[5], ctrl[3], ctrl[1], ctrl[0]}), 64'd0);
    chk("op7_imm", 64'(imm), 64'd0);
    idle(4);
    issue("fn9", rtype(5'd1, 5'd2, 5'd3, 6'd9));
    chk("fn9_ill", 64'(illegal), 64'd1);
    chk("fn9_bits", 64'({ctrl[9], ctrl[5], ctrl[3], ctrl[1], ctrl[0]}), 64'd0);
    idle(4);

    // Reset while waiting on a multiply
    issue("mul_rst", rtype(5'd1, 5'd2, 5'd9, 6'd50));
    step(); step();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_valid", 64'(dec_valid), 64'd0);
    chk("mrst_ctrl", 64'(ctrl), 64'd0);
    chk("mrst_imm", 64'(imm), 64'd0);
    chk("mrst_err", 64'(mul_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
